mem_stream_cntrl: RTL and testbench

MEM_STREAM_CNTRL -- requirements
Module: mem_stream_cntrl

---
 rtl/mem_cntrl_pkg.sv | 9 +
 rtl/sdp_ram.sv | 31 +++
 rtl/mem_stream_cntrl.sv | 171 +++++++++++++++++
 tb/tb_mem_stream_cntrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cntrl_pkg.sv
// rtl/mem_cntrl_pkg.sv - shared state encoding for the memory stream controller
package mem_cntrl_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
// Read data holds while re_i is low so the controller can park a fetched word here.
module sdp_ram #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ADDR-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [ADDR-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stream_cntrl.sv
// rtl/mem_stream_cntrl.sv - RAM-backed stream FIFO with a power-up clear pass
// Output path is two stages: RAM read register, then out_data register.
module mem_stream_cntrl
    import mem_cntrl_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               ADDR     = 10,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [ADDR:0]    level,
    output logic             init_done
);
    localparam int            LW       = ADDR + 1;
    localparam logic [ADDR:0] FULL_LVL = {1'b1, {ADDR{1'b0}}};

    state_e           state_q, state_d;
    logic [ADDR-1:0]  init_addr_q, init_addr_d;
    logic             init_done_q, init_done_d;
    logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]    level_q, level_d;
    logic             rd_vld_q, rd_vld_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             ram_we;
    logic [ADDR-1:0]  ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    logic             push;
    logic             pop;
    logic             init_last;
    logic             out_load;
    logic             rd_issue;
    logic [ADDR:0]    ram_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_vld_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_done_q <= init_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_vld_q    <= rd_vld_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
        end
    end

    assign init_last = (init_addr_q == {ADDR{1'b1}});

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_last) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // INIT owns the write port for the clear pass; RUN hands it to the push side.
    always_comb begin
        in_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wr_ptr_q;
        ram_wdata = in_data;
        case (state_q)
            S_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_addr_q;
                ram_wdata = INIT_VAL;
            end
            S_RUN: begin
                in_ready = (level_q < FULL_LVL);
                ram_we   = in_valid && (level_q < FULL_LVL);
            end
            default: ;
        endcase
    end

    assign push = in_valid && in_ready;
    assign pop  = out_vld_q && out_ready;

    // Words still in RAM: level counts everything, including the two output stages.
    assign ram_cnt  = level_q - LW'(rd_vld_q) - LW'(out_vld_q);
    assign out_load = rd_vld_q && (!out_vld_q || pop);
    assign rd_issue = (state_q == S_RUN) && (ram_cnt != '0) && (!rd_vld_q || out_load);

    always_comb begin
        init_addr_d = init_addr_q;
        init_done_d = init_done_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_vld_d    = rd_vld_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;

        if (state_q == S_INIT) begin
            init_addr_d = init_addr_q + ADDR'(1);
            if (init_last) begin
                init_done_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR'(1);
        end
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + ADDR'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (rd_issue) begin
            rd_vld_d = 1'b1;
        end else if (out_load) begin
            rd_vld_d = 1'b0;
        end

        if (out_load) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_rdata;
        end else if (pop) begin
            out_vld_d = 1'b0;
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign level     = level_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_stream_cntrl.sv
// tb/tb_mem_stream_cntrl.sv - scoreboard bench for mem_stream_cntrl
module tb_mem_stream_cntrl;
    localparam int         WIDTH    = 8;
    localparam int         ADDR     = 4;
    localparam int         DEPTH    = 16;
    localparam logic [7:0] INIT_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       init_done;

    mem_stream_cntrl #(
        .WIDTH    (WIDTH),
        .ADDR     (ADDR),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] exp_q[$];
    int         since_rst = 0;
    bit         can_push = 1'b0;
    bit         mon_run;
    int         mon_sz;
    bit         hold_prev = 1'b0;
    logic [7:0] data_prev;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference timing: the clear pass takes DEPTH edges after the last reset edge.
    always @(posedge clk) begin
        if (rst) since_rst <= 0;
        else if (since_rst < 1000) since_rst <= since_rst + 1;
    end

    // Monitor: compare state against the queue model and retire popped words.
    always @(negedge clk) begin
        mon_run = (since_rst >= DEPTH);
        mon_sz  = exp_q.size();
        chk("init_done", init_done, mon_run);
        chk("in_ready", in_ready, mon_run && (mon_sz < DEPTH));
        chk("level", level, mon_sz);
        if (!mon_run) chk("out_valid_idle", out_valid, 0);
        if (hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, data_prev);
        end
        hold_prev = out_valid && !out_ready && !rst;
        data_prev = out_data;
        can_push  = mon_run && (mon_sz < DEPTH);
        if (out_valid && out_ready) begin
            chk("pop_nonempty", mon_sz > 0, 1);
            if (mon_sz > 0) begin
                chk("out_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // Stimulus-side model: record each accepted word, drop everything on reset.
    always @(negedge clk) begin
        #1;
        if (rst) exp_q.delete();
        else if (in_valid && can_push) exp_q.push_back(in_data);
    end

    task automatic init_wait(input string name);
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk(name, init_done, (k == DEPTH) ? 1 : 0);
        end
        chk({name, "_ready"}, in_ready, 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        while (level != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, level, 0);
        chk({name, "_model"}, exp_q.size(), 0);
    endtask

    int npops;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        init_wait("init_done_edge");

        // Single word latency through the two output stages.
        tick(); in_valid = 1'b1; in_data = 8'h11;
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("lat_n", out_valid, 0);
        tick(); @(negedge clk); chk("lat_n1", out_valid, 0);
        tick(); @(negedge clk);
        chk("lat_n2_valid", out_valid, 1);
        chk("lat_n2_data", out_data, 8'h11);
        chk("lat_n2_level", level, 1);
        tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        @(negedge clk); chk("pop_level", level, 0);

        // Simultaneous push and pop at level 1.
        tick(); in_valid = 1'b1; in_data = 8'h22;
        tick(); in_valid = 1'b0;
        tick(); tick();
        @(negedge clk); chk("byp_pre_valid", out_valid, 1);
        in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
        tick(); in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); chk("byp_level", level, 1);
        tick(); tick();
        @(negedge clk);
        chk("byp_valid", out_valid, 1);
        chk("byp_data", out_data, 8'h33);
        tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0;

        // Fill to full, then try to overfill.
        for (int i = 0; i < DEPTH; i++) begin
            tick(); in_valid = 1'b1; in_data = 8'(i);
        end
        tick(); in_data = 8'hFF;
        @(negedge clk);
        chk("full_level", level, DEPTH);
        chk("full_ready", in_ready, 0);
        tick(); tick(); tick(); in_valid = 1'b0;
        @(negedge clk); chk("overfill_level", level, DEPTH);

        // Streaming at full rate across several pointer wraps.
        npops = 0;
        for (int k = 0; k < 40; k++) begin
            tick(); in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(8'h20 + k);
            @(negedge clk);
            if (out_valid) npops++;
        end
        chk("stream_no_gap", npops, 40);
        tick();
        drain("drain_stream");

        // Reset in the middle of RUN discards content and reruns the clear pass.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick(); in_valid = 1'b1; in_data = 8'(8'h40 + i);
        end
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("pre_rst_level", level, 9);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", init_done, 0);
        init_wait("reinit_done_edge");

        // Random traffic against the queue model.
        for (int c = 0; c < 10000; c++) begin
            tick();
            in_data = 8'($urandom);
            case (c / 2500)
                0:       begin in_valid = ($urandom_range(3) != 0); out_ready = ($urandom_range(2) == 0); end
                1:       begin in_valid = ($urandom_range(3) == 0); out_ready = ($urandom_range(3) != 0); end
                default: begin in_valid = ($urandom_range(1) == 0); out_ready = ($urandom_range(1) == 0); end
            endcase
        end
        tick();
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
